// File: rtl/encoder_pkg.sv
// Shared constants, FSM state type and helpers for the registered 4-to-2 encoder.
package encoder_pkg;

    localparam int N_REQ  = 4;
    localparam int CODE_W = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } enc_state_t;

    function automatic logic [2:0] popcount4(input logic [N_REQ-1:0] v);
        logic [2:0] sum;
        sum = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = sum + {2'b00, v[i]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/encoder_4x2_seq_pick.sv
// Combinational picker: first set bit of cand searching upward from start, wrapping.
module enc_pick4
    import encoder_pkg::*;
(
    input  logic [N_REQ-1:0]  cand,
    input  logic [CODE_W-1:0] start,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    logic [CODE_W-1:0] pos [N_REQ];

    // pos[k] is the k-th index visited; the 2-bit add provides the wrap.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pos
            assign pos[gi] = start + CODE_W'(gi);
        end
    endgenerate

    always_comb begin
        idx = start;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand[pos[k]]) begin
                idx = pos[k];
            end
        end
    end

    assign any = |cand;

endmodule

// File: rtl/encoder_4x2_seq.sv
// Registered 4-to-2 encoder with sticky pending set and valid/ready output.
// Define ENCODER_ROUND_ROBIN_EN for round-robin selection instead of fixed lowest-index priority.
module encoder_4x2_seq
    import encoder_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    output logic [CODE_W-1:0] out_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_REQ-1:0]  pending,
    output logic              err_multi,
    output logic [CNT_W-1:0]  enc_count
);

    enc_state_t        state_reg, state_next;
    logic [N_REQ-1:0]  pending_reg, pending_next;
    logic [CODE_W-1:0] code_reg, code_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              err_multi_reg;

    logic [N_REQ-1:0]  cand;
    logic [CODE_W-1:0] pick_start;
    logic [CODE_W-1:0] pick_idx;
    logic              pick_any;
    logic [N_REQ-1:0]  pick_onehot;
    logic              load;

    assign cand        = pending_reg | req;
    assign pick_onehot = N_REQ'(1) << pick_idx;

`ifdef ENCODER_ROUND_ROBIN_EN
    logic [CODE_W-1:0] ptr_reg;

    assign pick_start = ptr_reg + CODE_W'(1);

    // Reset value 3 makes the first grant after reset start the search at index 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_reg <= CODE_W'(N_REQ - 1);
        end else if (load) begin
            ptr_reg <= pick_idx;
        end
    end
`else
    assign pick_start = '0;
`endif

    enc_pick4 u_pick (
        .cand  (cand),
        .start (pick_start),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        code_next    = code_reg;
        count_next   = count_reg;
        load         = 1'b0;
        case (state_reg)
            IDLE: begin
                load = pick_any;
            end
            OFFER: begin
                if (out_ready) begin
                    count_next = count_reg + CNT_W'(1);
                    if (pick_any) begin
                        load = 1'b1;
                    end else begin
                        state_next   = IDLE;
                        pending_next = '0;
                    end
                end else begin
                    pending_next = cand;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // A new offer removes only its own bit; re-asserted requests for it stay latched.
        if (load) begin
            code_next    = pick_idx;
            pending_next = cand & ~pick_onehot;
            state_next   = OFFER;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            pending_reg   <= '0;
            code_reg      <= '0;
            count_reg     <= '0;
            err_multi_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            code_reg      <= code_next;
            count_reg     <= count_next;
            err_multi_reg <= (popcount4(req) >= 3'd2);
        end
    end

    assign out_code  = code_reg;
    assign out_valid = (state_reg == OFFER);
    assign pending   = pending_reg;
    assign err_multi = err_multi_reg;
    assign enc_count = count_reg;

endmodule

// File: tb/tb_encoder_4x2_seq.sv
// Self-checking bench for encoder_4x2_seq: vector table, scoreboard of expected codes, corner sequences.
module tb_encoder_4x2_seq;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       out_ready;
    logic [1:0] out_code;
    logic       out_valid;
    logic [3:0] pending;
    logic       err_multi;
    logic [7:0] enc_count;

    logic [1:0] w_code;
    logic       w_valid;
    logic [3:0] w_pending;
    logic       w_err;
    logic [1:0] w_count;

    encoder_4x2_seq #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .err_multi (err_multi),
        .enc_count (enc_count)
    );

    encoder_4x2_seq #(.CNT_W(2)) dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_code  (w_code),
        .out_valid (w_valid),
        .out_ready (out_ready),
        .pending   (w_pending),
        .err_multi (w_err),
        .enc_count (w_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic       ev;
        logic [1:0] ec;
        logic [3:0] ep;
        logic       ee;
        int         ecnt;
        int         npush;
        logic [5:0] codes;
    } vec_t;

    vec_t       tbl [17];
    logic [1:0] sb [$];
    int         n_total = 0;
    int         n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push_code(input logic [1:0] c);
        sb.push_back(c);
    endtask

    // Drive one cycle; a handshake seen before the edge is scored against the queue.
    task automatic step(input logic [3:0] r, input logic rdy);
        logic [1:0] e;
        req       = r;
        out_ready = rdy;
        #1;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL handshake: got code %0d with no code expected", out_code);
            end else begin
                e = sb.pop_front();
                $display("handshake code=%0d expected=%0d count=%0d", out_code, e, enc_count);
                chk("hs_code", {30'd0, out_code}, {30'd0, e});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_code"}, {30'd0, out_code}, 32'd0);
        chk({name, "_pending"}, {28'd0, pending}, 32'd0);
        chk({name, "_err"}, {31'd0, err_multi}, 32'd0);
        chk({name, "_count"}, {24'd0, enc_count}, 32'd0);
    endtask

    logic [1:0] lvl_seq [9];

    initial begin
        tbl[0]  = '{4'b0100, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 0, 1, 6'b000010};
        tbl[1]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1, 0, 6'b000000};
        tbl[2]  = '{4'b1011, 1'b1, 1'b1, 2'd0, 4'b1010, 1'b1, 1, 3, 6'b110100};
        tbl[3]  = '{4'b0000, 1'b1, 1'b1, 2'd1, 4'b1000, 1'b0, 2, 0, 6'b000000};
        tbl[4]  = '{4'b0000, 1'b1, 1'b1, 2'd3, 4'b0000, 1'b0, 3, 0, 6'b000000};
        tbl[5]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 4, 0, 6'b000000};
        tbl[6]  = '{4'b0001, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0, 4, 1, 6'b000000};
        tbl[7]  = '{4'b1000, 1'b0, 1'b1, 2'd0, 4'b1000, 1'b0, 4, 1, 6'b000011};
        tbl[8]  = '{4'b0000, 1'b0, 1'b1, 2'd0, 4'b1000, 1'b0, 4, 0, 6'b000000};
        tbl[9]  = '{4'b1000, 1'b0, 1'b1, 2'd0, 4'b1000, 1'b0, 4, 0, 6'b000000};
        tbl[10] = '{4'b0000, 1'b0, 1'b1, 2'd0, 4'b1000, 1'b0, 4, 0, 6'b000000};
        tbl[11] = '{4'b0000, 1'b1, 1'b1, 2'd3, 4'b0000, 1'b0, 5, 0, 6'b000000};
        tbl[12] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 6, 0, 6'b000000};
        tbl[13] = '{4'b0010, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0, 6, 1, 6'b000001};
        tbl[14] = '{4'b0010, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, 6, 1, 6'b000001};
        tbl[15] = '{4'b0000, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 7, 0, 6'b000000};
        tbl[16] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 8, 0, 6'b000000};

`ifdef ENCODER_ROUND_ROBIN_EN
        lvl_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
        lvl_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
`endif

        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        chk_zero("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(4'b0000, 1'b0);
            chk("idle_valid", {31'd0, out_valid}, 32'd0);
            chk("idle_pending", {28'd0, pending}, 32'd0);
            chk("idle_count", {24'd0, enc_count}, 32'd0);
        end

        for (int i = 0; i < 17; i++) begin
            for (int p = 0; p < tbl[i].npush; p++) begin
                push_code(tbl[i].codes[2*p +: 2]);
            end
            step(tbl[i].req, tbl[i].rdy);
            chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
            if (tbl[i].ev) begin
                chk($sformatf("v%0d_code", i), {30'd0, out_code}, {30'd0, tbl[i].ec});
            end
            chk($sformatf("v%0d_pending", i), {28'd0, pending}, {28'd0, tbl[i].ep});
            chk($sformatf("v%0d_err", i), {31'd0, err_multi}, {31'd0, tbl[i].ee});
            chk($sformatf("v%0d_count", i), {24'd0, enc_count}, tbl[i].ecnt);
        end

        // Level held on every request line, then released and drained.
        for (int i = 0; i < 9; i++) begin
            push_code(lvl_seq[i]);
        end
        for (int i = 0; i < 6; i++) begin
            step(4'b1111, 1'b1);
            chk($sformatf("lvl%0d_code", i), {30'd0, out_code}, {30'd0, lvl_seq[i]});
            chk($sformatf("lvl%0d_err", i), {31'd0, err_multi}, 32'd1);
        end
        for (int i = 6; i < 9; i++) begin
            step(4'b0000, 1'b1);
            chk($sformatf("lvl%0d_code", i), {30'd0, out_code}, {30'd0, lvl_seq[i]});
        end
        step(4'b0000, 1'b1);
        chk("lvl_end_valid", {31'd0, out_valid}, 32'd0);
        chk("lvl_end_count", {24'd0, enc_count}, 32'd17);

        // Reset while offering with requests pending.
        push_code(2'd0);
        step(4'b0111, 1'b0);
        chk("pre_rst_pending", {28'd0, pending}, 32'h6);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        step(4'b1111, 1'b1);
        sb.delete();
        chk_zero("midrst");
        rst_n = 1'b1;

        // Five handshakes: 8-bit counter reads 5, 2-bit counter wraps to 1.
        for (int i = 0; i < 5; i++) begin
            push_code(2'd0);
        end
        for (int i = 0; i < 5; i++) begin
            step(4'b0001, 1'b1);
        end
        step(4'b0000, 1'b1);
        chk("wrap_count8", {24'd0, enc_count}, 32'd5);
        chk("wrap_count2", {30'd0, w_count}, 32'd1);
        chk("wrap_valid", {31'd0, out_valid}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
